// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg -- shared widths, stall vector positions, operation encodings
// and the field layout of the ID->EX bus for the execute stage and its divider.
package ex_stage_pkg;

    localparam int STALL_BUS_WD = 6;
    localparam int ID_TO_EX_WD  = 146;
    localparam int EX_TO_MEM_WD = 76;

    // Positions inside the stall vector and the level meaning "hold this register".
    localparam int   STALL_EX  = 2;
    localparam int   STALL_MEM = 3;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_MFHI = 4'hB,
        ALU_MFLO = 4'hC,
        ALU_MTHI = 4'hD,
        ALU_MTLO = 4'hE,
        ALU_PASS = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        DIV_NONE     = 2'b00,
        DIV_SIGNED   = 2'b01,
        DIV_UNSIGNED = 2'b10,
        DIV_RSVD     = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    // Field order matches the ID->EX bus, most significant field first.
    typedef struct packed {
        logic [31:0] pc;
        alu_op_t     alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_rdata2;
        div_op_t     div_op;
    } id_to_ex_t;

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_en);
        return (signed_en && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// div -- iterative 32-bit restoring divider used by the execute stage.
// One quotient bit per cycle; results are presented for exactly one cycle
// (ready) after 32 iteration cycles.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             request a divide; sampled only while idle
//   signed_en         1 = signed divide, 0 = unsigned
//   opdata1, opdata2  dividend and divisor, captured on the start cycle
//   ready             high for the single cycle quotient/remainder are valid
//   quotient          quotient, sign-corrected
//   remainder         remainder, carries the dividend's sign
module div
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_en,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic        ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state;
    div_state_t  state_next;
    logic [4:0]  count;
    logic [31:0] divisor;
    logic [31:0] quo;        // shifts out dividend bits, shifts in quotient bits
    logic [31:0] rem;
    logic        neg_quo;
    logic        neg_rem;
    logic [32:0] shifted;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values that existed before the clock edge.
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_next; a missing
        // assignment on some branch would otherwise infer a latch.
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_BUSY;
            DIV_BUSY: if (count == 5'd31) state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // Partial remainder with the next dividend bit appended. Since the partial
    // remainder stays below the divisor, 33 bits always suffice.
    assign shifted = {rem, quo[31]};

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        // Operands are frozen here; later src changes are ignored.
                        divisor <= abs32(opdata2, signed_en);
                        quo     <= abs32(opdata1, signed_en);
                        rem     <= '0;
                        count   <= '0;
                        neg_quo <= signed_en & (opdata1[31] ^ opdata2[31]);
                        neg_rem <= signed_en & opdata1[31];
                    end
                end
                DIV_BUSY: begin
                    count <= count + 5'd1;
                    // A zero divisor always "fits", which naturally yields an
                    // all-ones quotient and the dividend as remainder.
                    if (shifted >= {1'b0, divisor}) begin
                        rem <= 32'(shifted - {1'b0, divisor});
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state == DIV_DONE);
    assign quotient  = neg_quo ? -quo : quo;
    assign remainder = neg_rem ? -rem : rem;

endmodule

// File: rtl/ex_stage.sv
// ex_stage -- execute stage: input pipeline register, ALU, data SRAM request,
// HI/LO registers and the multi-cycle divider with its stall request.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   stall                pipeline stall vector (bit 2 = this stage, bit 3 = MEM)
//   id_to_ex_bus         decoded instruction from ID
//   ex_to_mem_bus        {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   data_sram_*          data memory request (address = src1 + src2)
//   ex_to_id_forwarding  {rf_we, rf_waddr, ex_result} bypass to ID
//   ex_is_load           current instruction is a load (for load-use stalls)
//   stallreq_for_ex      divider needs the pipeline held
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic [37:0]             ex_to_id_forwarding,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex
);

    id_to_ex_t   ex_q;
    logic        insert_bubble;
    logic        advance;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_result;
    logic        div_valid;
    logic        div_signed;
    logic        div_start;
    logic        div_done;
    logic        div_ready;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    // ---------------------------------------------------------------- input register
    assign insert_bubble = (stall[STALL_EX] == STOP) && (stall[STALL_MEM] == NO_STOP);
    assign advance       = (stall[STALL_EX] == NO_STOP);

    always_ff @(posedge clk) begin
        if (rst || insert_bubble) begin
            ex_q <= '0;
        end else if (advance) begin
            ex_q <= id_to_ex_t'(id_to_ex_bus);
        end
    end

    // ---------------------------------------------------------------- ALU
    always_comb begin
        alu_result = '0;
        case (ex_q.alu_op)
            ALU_ADD:  alu_result = ex_q.src1 + ex_q.src2;
            ALU_SUB:  alu_result = ex_q.src1 - ex_q.src2;
            ALU_AND:  alu_result = ex_q.src1 & ex_q.src2;
            ALU_OR:   alu_result = ex_q.src1 | ex_q.src2;
            ALU_XOR:  alu_result = ex_q.src1 ^ ex_q.src2;
            ALU_NOR:  alu_result = ~(ex_q.src1 | ex_q.src2);
            ALU_SLT:  alu_result = {31'b0, $signed(ex_q.src1) < $signed(ex_q.src2)};
            ALU_SLTU: alu_result = {31'b0, ex_q.src1 < ex_q.src2};
            ALU_SLL:  alu_result = ex_q.src2 << ex_q.src1[4:0];
            ALU_SRL:  alu_result = ex_q.src2 >> ex_q.src1[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(ex_q.src2) >>> ex_q.src1[4:0]);
            ALU_MFHI: alu_result = hi;
            ALU_MFLO: alu_result = lo;
            default:  alu_result = ex_q.src1;   // MTHI, MTLO and pass-through
        endcase
    end

    // ---------------------------------------------------------------- divider control
    assign div_valid  = (ex_q.div_op == DIV_SIGNED) || (ex_q.div_op == DIV_UNSIGNED);
    assign div_signed = (ex_q.div_op == DIV_SIGNED);

    // Once a divide has produced its result, the same instruction may linger
    // in EX if something downstream stalls; div_done keeps it from starting a
    // second time. Any reload of the EX register means a new instruction.
    always_ff @(posedge clk) begin
        if (rst || insert_bubble || advance) begin
            div_done <= 1'b0;
        end else if (div_ready) begin
            div_done <= 1'b1;
        end
    end

    assign div_start = div_valid & ~div_done;

    // High from the idle cycle that launches the divide through the last busy
    // cycle; drops in the result cycle so the divide retires as HI/LO update.
    assign stallreq_for_ex = div_start & ~div_ready;

    div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_en (div_signed),
        .opdata1   (ex_q.src1),
        .opdata2   (ex_q.src2),
        .ready     (div_ready),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // ---------------------------------------------------------------- HI / LO
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_ready) begin
            hi <= div_remainder;
            lo <= div_quotient;
        end else if (advance) begin
            if (ex_q.alu_op == ALU_MTHI) hi <= ex_q.src1;
            if (ex_q.alu_op == ALU_MTLO) lo <= ex_q.src1;
        end
    end

    // ---------------------------------------------------------------- outputs
    // A bubble is an all-zero register, so every output below reads zero.
    assign data_sram_en    = ex_q.data_ram_en;
    assign data_sram_wen   = ex_q.data_ram_wen;
    assign data_sram_addr  = ex_q.src1 + ex_q.src2;
    assign data_sram_wdata = ex_q.rf_rdata2;

    assign ex_to_mem_bus = {ex_q.pc, ex_q.data_ram_en, ex_q.data_ram_wen,
                            ex_q.sel_rf_res, ex_q.rf_we, ex_q.rf_waddr, alu_result};

    assign ex_to_id_forwarding = {ex_q.rf_we, ex_q.rf_waddr, alu_result};
    assign ex_is_load          = ex_q.data_ram_en & ex_q.sel_rf_res;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   ext_stall;
    logic [5:0]   stall;
    logic [145:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [37:0]  ex_to_id_forwarding;
    logic         ex_is_load;
    logic         stallreq_for_ex;

    int checks = 0;
    int errors = 0;

    // Reference HI/LO state
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    always #5 clk = ~clk;

    // Minimal stall controller: a divider request holds IF, ID, EX and MEM inputs.
    assign stall = ext_stall | (stallreq_for_ex ? 6'b001111 : 6'b000000);

    ex_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .id_to_ex_bus        (id_to_ex_bus),
        .ex_to_mem_bus       (ex_to_mem_bus),
        .data_sram_en        (data_sram_en),
        .data_sram_wen       (data_sram_wen),
        .data_sram_addr      (data_sram_addr),
        .data_sram_wdata     (data_sram_wdata),
        .ex_to_id_forwarding (ex_to_id_forwarding),
        .ex_is_load          (ex_is_load),
        .stallreq_for_ex     (stallreq_for_ex)
    );

    // ------------------------------------------------------------ model helpers
    function automatic logic [145:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic en, input logic [3:0] wen,
                                        input logic sel, input logic we, input logic [4:0] wa,
                                        input logic [31:0] rd2, input logic [1:0] dop);
        return {pc, op, s1, s2, en, wen, sel, we, wa, rd2, dop};
    endfunction

    function automatic logic [145:0] rand_instr(input logic [3:0] op);
        return mk($urandom, op, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, 2'b00);
    endfunction

    function automatic logic [31:0] alu_model(input logic [145:0] ins);
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        op = ins[113:110];
        a  = ins[109:78];
        b  = ins[77:46];
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'h7: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'h8: return 32'(longint'(b) * (longint'(1) << a[4:0]));
            4'h9: return 32'(longint'(b) / (longint'(1) << a[4:0]));
            4'hA: return 32'(longint'($signed(b)) >>> a[4:0]);
            4'hB: return hi_m;
            4'hC: return lo_m;
            default: return a;
        endcase
    endfunction

    function automatic logic [75:0] exp_mem_bus(input logic [145:0] ins);
        return {ins[145:114], ins[45], ins[44:41], ins[40], ins[39], ins[38:34], alu_model(ins)};
    endfunction

    function automatic logic [68:0] exp_sram(input logic [145:0] ins);
        logic [31:0] addr;
        addr = ins[109:78] + ins[77:46];
        return {ins[45], ins[44:41], addr, ins[33:2]};
    endfunction

    // MTHI/MTLO result value is not architecturally defined; exclude it.
    function automatic logic [31:0] result_mask(input logic [145:0] ins);
        return (ins[113:110] == 4'hD || ins[113:110] == 4'hE) ? 32'h0 : 32'hFFFFFFFF;
    endfunction

    function automatic void model_retire(input logic [145:0] ins);
        if (ins[113:110] == 4'hD) hi_m = ins[109:78];
        if (ins[113:110] == 4'hE) lo_m = ins[109:78];
    endfunction

    task automatic div_model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                             output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        if (sb == 0) begin
            qq = 64'h0000_0000_FFFF_FFFF;
            rr = (sa < 0) ? -sa : sa;
            if (sa < 0) begin
                qq = -qq;
                rr = -rr;
            end
        end else begin
            qq = sa / sb;
            rr = sa % sb;
        end
        q = qq[31:0];
        r = rr[31:0];
    endtask

    // All tasks start and end just after a falling edge.
    task automatic run_instr(input logic [145:0] ins);
        id_to_ex_bus = ins;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic count_stallreq(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stallreq_for_ex) cnt++;
            else break;
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        ext_stall = 6'b0;
        id_to_ex_bus = rand_instr(4'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ex_to_mem_bus !== 76'b0) begin
            errors++; $display("FAIL reset_mem_bus got %h expected 0", ex_to_mem_bus);
        end
        checks++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== 69'b0) begin
            errors++; $display("FAIL reset_sram got en=%b addr=%h wdata=%h expected zeros",
                               data_sram_en, data_sram_addr, data_sram_wdata);
        end
        checks++;
        if ({ex_to_id_forwarding, ex_is_load, stallreq_for_ex} !== 40'b0) begin
            errors++; $display("FAIL reset_misc got fwd=%h load=%b stallreq=%b expected zeros",
                               ex_to_id_forwarding, ex_is_load, stallreq_for_ex);
        end
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
    endtask

    task automatic test_alu_random();
        logic [145:0] ins;
        logic [75:0]  mask_bus;
        logic [37:0]  mask_fwd;
        logic [31:0]  exp_res;
        for (int i = 0; i < 64; i++) begin
            ins = rand_instr(4'(i % 16));
            if (i % 7 == 3) ins[77:46] = ins[109:78];   // equal operands for compares
            exp_res  = alu_model(ins);
            mask_bus = {44'hFFF_FFFF_FFFF, result_mask(ins)};
            mask_fwd = {6'h3F, result_mask(ins)};
            run_instr(ins);
            checks++;
            if ((ex_to_mem_bus & mask_bus) !== (exp_mem_bus(ins) & mask_bus)) begin
                errors++; $display("FAIL alu_bus[%0d] op=%h got %h expected %h",
                                   i, ins[113:110], ex_to_mem_bus, exp_mem_bus(ins));
            end
            checks++;
            if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== exp_sram(ins)) begin
                errors++; $display("FAIL alu_sram[%0d] got %h expected %h", i,
                                   {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                                   exp_sram(ins));
            end
            checks++;
            if ((ex_to_id_forwarding & mask_fwd) !== ({ins[39], ins[38:34], exp_res} & mask_fwd)) begin
                errors++; $display("FAIL alu_fwd[%0d] got %h expected %h", i,
                                   ex_to_id_forwarding, {ins[39], ins[38:34], exp_res});
            end
            checks++;
            if (ex_is_load !== (ins[45] & ins[40])) begin
                errors++; $display("FAIL alu_is_load[%0d] got %b expected %b", i,
                                   ex_is_load, ins[45] & ins[40]);
            end
            model_retire(ins);
        end
    endtask

    task automatic test_add_overflow();
        run_instr(mk(32'hBFC0_0010, 4'h0, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1,
                     5'd9, 32'h0, 2'b00));
        checks++;
        if (ex_to_mem_bus[31:0] !== 32'h8000_0000) begin
            errors++; $display("FAIL add_wrap got %h expected 80000000", ex_to_mem_bus[31:0]);
        end
        checks++;
        if (ex_to_id_forwarding !== {1'b1, 5'd9, 32'h8000_0000}) begin
            errors++; $display("FAIL add_fwd got %h expected %h", ex_to_id_forwarding,
                               {1'b1, 5'd9, 32'h8000_0000});
        end
    endtask

    task automatic test_store();
        run_instr(mk(32'hBFC0_0020, 4'h0, 32'h1000, 32'h8, 1'b1, 4'hF, 1'b0, 1'b0,
                     5'd0, 32'hDEAD_BEEF, 2'b00));
        checks++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !==
            {1'b1, 4'hF, 32'h1008, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL store got en=%b wen=%h addr=%h wdata=%h expected 1 f 00001008 deadbeef",
                               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        checks++;
        if (ex_to_mem_bus[31:0] !== 32'h1008 || ex_is_load !== 1'b0) begin
            errors++; $display("FAIL store_result got %h load=%b expected 00001008 0",
                               ex_to_mem_bus[31:0], ex_is_load);
        end
    endtask

    task automatic test_bubble_hold();
        logic [145:0] a;
        a = rand_instr(4'h3);
        a[45] = 1'b1;
        run_instr(a);
        // Bubble: EX stopped, MEM running
        ext_stall = 6'b000100;
        run_instr(rand_instr(4'h4));
        checks++;
        if (ex_to_mem_bus !== 76'b0 || data_sram_en !== 1'b0) begin
            errors++; $display("FAIL bubble got bus=%h en=%b expected 0 0", ex_to_mem_bus, data_sram_en);
        end
        ext_stall = 6'b000000;
        run_instr(a);
        // Hold: EX and MEM stopped, new input ignored
        ext_stall = 6'b001100;
        run_instr(rand_instr(4'h2));
        checks++;
        if (ex_to_mem_bus !== exp_mem_bus(a) || data_sram_addr !== exp_sram(a)[63:32]) begin
            errors++; $display("FAIL hold got %h expected %h", ex_to_mem_bus, exp_mem_bus(a));
        end
        ext_stall = 6'b000000;
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input string name);
        logic [31:0] q;
        logic [31:0] r;
        int cnt;
        div_model(a, b, sgn, q, r);
        id_to_ex_bus = mk(32'hBFC0_0100, 4'h0, a, b, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                          sgn ? 2'b01 : 2'b10);
        @(posedge clk);
        #1 id_to_ex_bus = mk(32'hBFC0_0104, 4'hC, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1,
                             5'd2, 32'h0, 2'b00);
        count_stallreq(cnt);
        checks++;
        if (cnt != 33) begin
            errors++; $display("FAIL %s stallreq_cycles got %0d expected 33", name, cnt);
        end
        hi_m = r;
        lo_m = q;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ex_to_mem_bus[31:0] !== q) begin
            errors++; $display("FAIL %s mflo got %h expected %h", name, ex_to_mem_bus[31:0], q);
        end
        run_instr(mk(32'hBFC0_0108, 4'hB, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0, 2'b00));
        checks++;
        if (ex_to_mem_bus[31:0] !== r) begin
            errors++; $display("FAIL %s mfhi got %h expected %h", name, ex_to_mem_bus[31:0], r);
        end
    endtask

    task automatic test_divides();
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        do_div(32'd100, 32'd0, 1'b0, "divu_100_0");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1");
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1, "div_m5_0");
        for (int i = 0; i < 4; i++) begin
            do_div($urandom, 32'($urandom_range(1, 1000)), 1'(i % 2), "div_rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q1, r1, q2, r2;
        int cnt1, cnt2;
        div_model(32'd1000, 32'd7, 1'b0, q1, r1);
        div_model(32'hFFFF_FC18, 32'd9, 1'b1, q2, r2);
        id_to_ex_bus = mk(32'h200, 4'h0, 32'd1000, 32'd7, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 2'b10);
        @(posedge clk);
        #1 id_to_ex_bus = mk(32'h204, 4'h0, 32'hFFFF_FC18, 32'd9, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 2'b01);
        count_stallreq(cnt1);
        @(posedge clk);
        #1 id_to_ex_bus = mk(32'h208, 4'hC, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h0, 2'b00);
        count_stallreq(cnt2);
        checks++;
        if (cnt1 != 33 || cnt2 != 33) begin
            errors++; $display("FAIL b2b_stallreq got %0d,%0d expected 33,33", cnt1, cnt2);
        end
        hi_m = r2;
        lo_m = q2;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ex_to_mem_bus[31:0] !== q2) begin
            errors++; $display("FAIL b2b_mflo got %h expected %h", ex_to_mem_bus[31:0], q2);
        end
    endtask

    task automatic test_div_held();
        logic [31:0] q, r;
        int cnt;
        int late;
        div_model(32'd12345, 32'd100, 1'b0, q, r);
        id_to_ex_bus = mk(32'h300, 4'h0, 32'd12345, 32'd100, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 2'b10);
        @(posedge clk);
        #1;
        ext_stall = 6'b001111;
        id_to_ex_bus = mk(32'h304, 4'hB, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0, 2'b00);
        count_stallreq(cnt);
        late = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (stallreq_for_ex) late++;
        end
        checks++;
        if (cnt != 33 || late != 0) begin
            errors++; $display("FAIL held_no_restart got cycles=%0d extra=%0d expected 33 0", cnt, late);
        end
        ext_stall = 6'b000000;
        hi_m = r;
        lo_m = q;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ex_to_mem_bus[31:0] !== r) begin
            errors++; $display("FAIL held_mfhi got %h expected %h", ex_to_mem_bus[31:0], r);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [145:0] mfhi;
        logic [145:0] mflo;
        mfhi = mk(32'h404, 4'hB, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h0, 2'b00);
        mflo = mk(32'h408, 4'hC, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h0, 2'b00);
        run_instr(mk(32'h3F0, 4'hD, 32'h1234, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 2'b00));
        run_instr(mk(32'h3F4, 4'hE, 32'h5678, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 2'b00));
        id_to_ex_bus = mk(32'h400, 4'h0, 32'd100, 32'd7, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 2'b10);
        @(posedge clk);
        #1 id_to_ex_bus = mfhi;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (stallreq_for_ex !== 1'b0 || ex_to_mem_bus !== 76'b0 || data_sram_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_div got stallreq=%b bus=%h expected 0 0",
                               stallreq_for_ex, ex_to_mem_bus);
        end
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        run_instr(mfhi);
        checks++;
        if (ex_to_mem_bus[31:0] !== 32'h0 || stallreq_for_ex !== 1'b0) begin
            errors++; $display("FAIL rst_hi got %h stallreq=%b expected 0 0",
                               ex_to_mem_bus[31:0], stallreq_for_ex);
        end
        // Long enough for an aborted divide to have finished if it were still running
        repeat (40) run_instr(mfhi);
        run_instr(mflo);
        checks++;
        if (ex_to_mem_bus[31:0] !== 32'h0) begin
            errors++; $display("FAIL rst_lo_after_wait got %h expected 0", ex_to_mem_bus[31:0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        ext_stall = 6'b0;
        id_to_ex_bus = '0;
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        test_reset();
        test_alu_random();
        test_add_overflow();
        test_store();
        test_bubble_hold();
        test_divides();
        test_back_to_back();
        test_div_held();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
